// File: rtl/fp_add_arbiter.sv
// Round-robin front end that time-shares one combinational FP adder among NUM_REQ engines.
// Each accepted operand pair is registered onto the adder inputs, settled for a cycle, and returned with its ID.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_result,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] idx;
  logic            gnt_found;
  logic            accept;

  // Search starts just past the previous winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign accept    = (state == IDLE) && gnt_found && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      add_a      <= '0;
      add_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      ops_done   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (accept) begin
          add_a      <= req_a[32*gnt_idx +: 32];
          add_b      <= req_b[32*gnt_idx +: 32];
          rsp_id     <= gnt_idx;
          last_grant <= gnt_idx;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_data  <= add_result;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          if (ops_done != '1) ops_done <= ops_done + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed grant table, random traffic against a round-robin model, async reset checks.
module tb_fp_add_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic [31:0]  add_a, add_b, add_result;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_ready;
  logic         busy;
  logic [1:0]   ops_done;

  int vectors = 0;
  int miscompares = 0;
  int model_last = 3;
  int model_ops = 0;

  always #5 clk = ~clk;

  // Adder stub: plain integer add stands in for the FP adder.
  assign add_result = add_a + add_b;

  fp_add_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .ops_done(ops_done)
  );

  typedef struct {
    logic [3:0]  v;
    int          bp;
    int          g;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // First valid index after the previous winner, wrapping modulo 4.
  function automatic int model_grant(input logic [3:0] v);
    for (int k = 1; k <= 4; k++)
      if (v[(model_last + k) % 4]) return (model_last + k) % 4;
    return -1;
  endfunction

  // One full operation; exp_g < 0 lets the model pick the winner.
  task automatic run_op(input logic [3:0] v, input int bp, input int exp_g,
                        input logic [31:0] fa, input logic [31:0] fb);
    int g;
    logic [3:0]  oh;
    logic [31:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
    end
    g = (exp_g >= 0) ? exp_g : model_grant(v);
    if (fa != 0) begin
      req_a[g*32 +: 32] = fa;
      req_b[g*32 +: 32] = fb;
    end
    req_valid = v;
    #1;
    oh = 4'b0001 << g;
    ea = req_a[g*32 +: 32];
    eb = req_b[g*32 +: 32];
    chk("idle_req_ready", req_ready, oh);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    chk("exec_busy", busy, 1);
    chk("exec_req_ready", req_ready, 0);
    chk("exec_add_a", add_a, ea);
    chk("exec_add_b", add_b, eb);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_id", rsp_id, g);
    chk("resp_data", rsp_data, ea + eb);
    chk("resp_req_ready", req_ready, 0);
    repeat (bp) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, g);
      chk("bp_data", rsp_data, ea + eb);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_ops = (model_ops == 3) ? 3 : model_ops + 1;
    model_last = g;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_ops", ops_done, model_ops);
    chk("done_add_a_hold", add_a, ea);
  endtask

  // Starts an op for requester 0, then asserts reset mid-EXEC between edges.
  task automatic reset_mid_exec();
    req_a[31:0] = 32'h1234_5678;
    req_b[31:0] = 32'h0000_0010;
    req_valid = 4'b0001;
    #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_add_a", add_a, 32'h1234_5678);
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("rst_held_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    #1;
    model_last = 3;
    model_ops = 0;
    chk("post_rst_req_ready", req_ready, 4'b0001);
    chk("post_rst_busy", busy, 0);
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 0, 2, 32'h3F80_0000, 32'h0000_0001};
    tbl[1]  = '{4'b1000, 0, 3, 32'h0, 32'h0};
    tbl[2]  = '{4'b1111, 0, 0, 32'h0, 32'h0};
    tbl[3]  = '{4'b1111, 0, 1, 32'h0, 32'h0};
    tbl[4]  = '{4'b1111, 0, 2, 32'h0, 32'h0};
    tbl[5]  = '{4'b1111, 0, 3, 32'h0, 32'h0};
    tbl[6]  = '{4'b1111, 0, 0, 32'h0, 32'h0};
    tbl[7]  = '{4'b0010, 5, 1, 32'h0, 32'h0};
    tbl[8]  = '{4'b1000, 0, 3, 32'h0, 32'h0};
    tbl[9]  = '{4'b0110, 0, 1, 32'h0, 32'h0};
    tbl[10] = '{4'b0110, 0, 2, 32'h0, 32'h0};
    tbl[11] = '{4'b1000, 0, 3, 32'h0, 32'h0};
    tbl[12] = '{4'b1001, 0, 0, 32'h0, 32'h0};

    rst = 1'b1;
    req_valid = 4'b0001;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst_req_ready", req_ready, 0);
    chk("in_rst_ops_done", ops_done, 0);
    rst = 1'b0;
    #1;
    reset_mid_exec();

    foreach (tbl[i]) run_op(tbl[i].v, tbl[i].bp, tbl[i].g, tbl[i].a, tbl[i].b);

    // Random traffic, with occasional empty cycles, against the model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 4'b0000;
        #1;
        chk("empty_req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("empty_busy", busy, 0);
      end
      run_op(4'($urandom_range(1, 15)), $urandom_range(0, 3), -1, 32'h0, 32'h0);
    end

    reset_mid_exec();
    run_op(4'b1111, 0, 0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
